// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns one memory-bus slot per cycle and gives it either to an instruction
//   fetch at the program counter or to a load/store from a later pipeline
//   stage. It applies jump redirects and stops fetching once halted. Its
//   registered status outputs describe what is on mem_data this cycle, which
//   is the result of the slot issued in the previous cycle.
//
// Ports
//   clock, reset        : clock, asynchronous active-high reset
//   halting             : enter HALTED at this edge
//   jump, jump_address  : one-cycle redirect, target word-aligned
//   data_req/data_write : later stage claims the slot (store when data_write=1)
//   data_address        : load/store address, passed through unchanged
//   data_wr_value       : store data
//   mem_address/mem_read/mem_write/mem_wr_data : combinational bus drive
//   block_fetch         : registered, mem_data is not a valid instruction
//   data_ack            : registered, mem_data holds last cycle's load result
//   fetch_pc            : registered, address of the instruction on mem_data
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        halting,
    input  logic        jump,
    input  logic [31:0] jump_address,
    input  logic        data_req,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_wr_value,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wr_data,
    output logic        block_fetch,
    output logic        data_ack,
    output logic [31:0] fetch_pc
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic        block_fetch_reg;
    logic        data_ack_reg;
    logic [31:0] fetch_pc_reg;

    logic        running;
    logic        data_slot;
    logic [31:0] jump_target;

    assign running     = (state_reg == RUN);
    assign data_slot   = running && data_req;
    assign jump_target = jump_address & 32'hFFFF_FFFC;

    // Bus drive: data slot, fetch slot, or idle (halted, address parked on pc).
    always_comb begin
        mem_address = pc_reg;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        if (data_slot) begin
            mem_address = data_address;
            mem_read    = !data_write;
            mem_write   = data_write;
        end else if (running) begin
            mem_read    = 1'b1;
        end
    end

    assign mem_wr_data = data_wr_value;
    assign block_fetch = block_fetch_reg;
    assign data_ack    = data_ack_reg;
    assign fetch_pc    = fetch_pc_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= RUN;
            pc_reg          <= RESET_PC;
            block_fetch_reg <= 1'b1;
            data_ack_reg    <= 1'b0;
            fetch_pc_reg    <= RESET_PC;
        end else if (running) begin
            // A jump overrides the increment; a data slot holds the pc.
            if (jump) begin
                pc_reg <= jump_target;
            end else if (!data_req) begin
                pc_reg <= pc_reg + 32'd4;
            end

            if (!data_req) begin
                fetch_pc_reg <= pc_reg;
            end

            if (halting) begin
                // The halting cycle's slot still issues, but from the next
                // cycle on nothing is reported as valid.
                state_reg       <= HALTED;
                block_fetch_reg <= 1'b1;
                data_ack_reg    <= 1'b0;
            end else begin
                // A fetch issued alongside a jump is wrong-path: squash it.
                block_fetch_reg <= data_req || jump;
                data_ack_reg    <= data_req && !data_write;
            end
        end else begin
            block_fetch_reg <= 1'b1;
            data_ack_reg    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: a directed vector table, a wrap-around
// instance, asynchronous reset checks and a randomized run against a
// slot-history reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halting = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_address = '0;
    logic        data_req = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_address = '0;
    logic [31:0] data_wr_value = '0;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wr_data;
    logic        block_fetch;
    logic        data_ack;
    logic [31:0] fetch_pc;

    logic [31:0] w_mem_address;
    logic        w_mem_read;
    logic        w_mem_write;
    logic [31:0] w_mem_wr_data;
    logic        w_block_fetch;
    logic        w_data_ack;
    logic [31:0] w_fetch_pc;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clock(clk), .reset(rst), .halting(halting), .jump(jump),
        .jump_address(jump_address), .data_req(data_req), .data_write(data_write),
        .data_address(data_address), .data_wr_value(data_wr_value),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wr_data(mem_wr_data), .block_fetch(block_fetch), .data_ack(data_ack),
        .fetch_pc(fetch_pc)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clock(clk), .reset(rst), .halting(1'b0), .jump(1'b0),
        .jump_address(32'h0), .data_req(1'b0), .data_write(1'b0),
        .data_address(32'h0), .data_wr_value(32'h0),
        .mem_address(w_mem_address), .mem_read(w_mem_read), .mem_write(w_mem_write),
        .mem_wr_data(w_mem_wr_data), .block_fetch(w_block_fetch), .data_ack(w_data_ack),
        .fetch_pc(w_fetch_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        halting = 0; jump = 0; jump_address = 0;
        data_req = 0; data_write = 0; data_address = 0; data_wr_value = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        next_cycle();
        next_cycle();
        rst = 0;  // released 1 unit after an edge: this cycle is cycle 0
    endtask

    typedef struct {
        logic        halting, jump;
        logic [31:0] ja;
        logic        dreq, dwr;
        logic [31:0] daddr, wdata;
        logic [31:0] e_addr;
        logic        e_rd, e_wr, e_bf, e_ack;
        logic [31:0] e_fpc;
    } vec_t;

    // ---------------- reference model (slot history) ----------------
    typedef enum int { S_NONE, S_FETCH, S_LOAD, S_STORE, S_IDLE } slot_kind_t;
    typedef struct {
        slot_kind_t kind;
        logic       jumped;
        logic       halt_edge;
    } slot_t;

    logic [31:0] m_pc;
    bit          m_halted;
    slot_t       m_prev;
    logic [31:0] m_fetches[$];

    task automatic model_reset(input logic [31:0] rpc);
        m_pc = rpc;
        m_halted = 0;
        m_prev = '{S_NONE, 1'b0, 1'b0};
        m_fetches.delete();
        m_fetches.push_back(rpc);
    endtask

    task automatic model_check(input int cyc);
        logic [31:0] e_addr;
        logic e_rd, e_wr, e_bf, e_ack;
        if (m_halted) begin
            e_addr = m_pc; e_rd = 0; e_wr = 0;
        end else if (data_req) begin
            e_addr = data_address; e_rd = !data_write; e_wr = data_write;
        end else begin
            e_addr = m_pc; e_rd = 1; e_wr = 0;
        end
        e_bf  = !(m_prev.kind == S_FETCH && !m_prev.jumped && !m_prev.halt_edge);
        e_ack = (m_prev.kind == S_LOAD) && !m_prev.halt_edge;
        chk("rnd_mem_address", mem_address, e_addr);
        chk("rnd_mem_rw", {30'b0, mem_read, mem_write}, {30'b0, e_rd, e_wr});
        chk("rnd_status", {30'b0, block_fetch, data_ack}, {30'b0, e_bf, e_ack});
        chk("rnd_fetch_pc", fetch_pc, m_fetches[$]);
        chk("rnd_wr_data", mem_wr_data, data_wr_value);
        if (cyc % 50 == 0)
            $display("rnd cycle %0d addr=%08h rd=%0b wr=%0b bf=%0b ack=%0b fpc=%08h",
                     cyc, mem_address, mem_read, mem_write, block_fetch, data_ack, fetch_pc);
    endtask

    task automatic model_step();
        if (m_halted) begin
            m_prev = '{S_IDLE, 1'b0, 1'b0};
        end else begin
            if (data_req) begin
                m_prev.kind = data_write ? S_STORE : S_LOAD;
            end else begin
                m_prev.kind = S_FETCH;
                m_fetches.push_back(m_pc);
            end
            m_prev.jumped    = jump;
            m_prev.halt_edge = halting;
            if (jump)          m_pc = {jump_address[31:2], 2'b00};
            else if (!data_req) m_pc = m_pc + 32'd4;
            if (halting)       m_halted = 1;
        end
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl[11];

    initial begin
        //            halt jmp ja           req wr daddr        wdata         addr         rd wr bf ack fpc
        tbl[0]  = '{0, 0, 32'h0,       0, 0, 32'h0,   32'h0,       32'h0,   1, 0, 1, 0, 32'h0};
        tbl[1]  = '{0, 0, 32'h0,       0, 0, 32'h0,   32'h0,       32'h4,   1, 0, 0, 0, 32'h0};
        tbl[2]  = '{0, 0, 32'h0,       1, 0, 32'h100, 32'h0,       32'h100, 1, 0, 0, 0, 32'h4};
        tbl[3]  = '{0, 1, 32'h203,     0, 0, 32'h0,   32'h0,       32'h8,   1, 0, 1, 1, 32'h4};
        tbl[4]  = '{0, 0, 32'h0,       0, 0, 32'h0,   32'h0,       32'h200, 1, 0, 1, 0, 32'h8};
        tbl[5]  = '{0, 1, 32'h406,     1, 1, 32'h300, 32'hDEADBEEF, 32'h300, 0, 1, 0, 0, 32'h200};
        tbl[6]  = '{0, 0, 32'h0,       0, 0, 32'h0,   32'h0,       32'h404, 1, 0, 1, 0, 32'h200};
        tbl[7]  = '{1, 0, 32'h0,       0, 0, 32'h0,   32'h0,       32'h408, 1, 0, 0, 0, 32'h404};
        tbl[8]  = '{0, 0, 32'h0,       0, 0, 32'h0,   32'h0,       32'h40C, 0, 0, 1, 0, 32'h408};
        tbl[9]  = '{0, 1, 32'h800,     1, 1, 32'h500, 32'h1234,    32'h40C, 0, 0, 1, 0, 32'h408};
        tbl[10] = '{0, 0, 32'h0,       0, 0, 32'h0,   32'h0,       32'h40C, 0, 0, 1, 0, 32'h408};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            halting = tbl[i].halting; jump = tbl[i].jump; jump_address = tbl[i].ja;
            data_req = tbl[i].dreq; data_write = tbl[i].dwr;
            data_address = tbl[i].daddr; data_wr_value = tbl[i].wdata;
            #3;
            chk($sformatf("tbl%0d_addr", i), mem_address, tbl[i].e_addr);
            chk($sformatf("tbl%0d_rw", i), {30'b0, mem_read, mem_write}, {30'b0, tbl[i].e_rd, tbl[i].e_wr});
            chk($sformatf("tbl%0d_bf_ack", i), {30'b0, block_fetch, data_ack}, {30'b0, tbl[i].e_bf, tbl[i].e_ack});
            chk($sformatf("tbl%0d_fetch_pc", i), fetch_pc, tbl[i].e_fpc);
            chk($sformatf("tbl%0d_wr_data", i), mem_wr_data, tbl[i].wdata);
            if (i < 3)
                chk($sformatf("wrap%0d_addr", i), w_mem_address, 32'hFFFF_FFF8 + 32'(4 * i));
            $display("vec %0d addr=%08h rd=%0b wr=%0b bf=%0b ack=%0b fpc=%08h",
                     i, mem_address, mem_read, mem_write, block_fetch, data_ack, fetch_pc);
            next_cycle();
        end

        // Asynchronous reset mid-cycle while halted: values restored at once.
        idle_inputs();
        #2;
        rst = 1;
        #1;
        chk("async_rst_addr", mem_address, 32'h0);
        chk("async_rst_rw", {30'b0, mem_read, mem_write}, 32'h2);
        chk("async_rst_bf_ack", {30'b0, block_fetch, data_ack}, 32'h2);
        chk("async_rst_fetch_pc", fetch_pc, 32'h0);
        chk("async_rst_wrap_fpc", w_fetch_pc, 32'hFFFF_FFF8);
        $display("async reset addr=%08h bf=%0b fpc=%08h", mem_address, block_fetch, fetch_pc);
        next_cycle();
        rst = 0;

        // Wrap-around free run on the second instance: check pc sequence and
        // that fetch_pc follows one cycle behind.
        for (int i = 0; i < 4; i++) begin
            #3;
            chk($sformatf("wrapfree%0d_addr", i), w_mem_address, 32'hFFFF_FFF8 + 32'(4 * i));
            chk($sformatf("wrapfree%0d_bf", i), {31'b0, w_block_fetch}, (i == 0) ? 32'h1 : 32'h0);
            $display("wrap %0d addr=%08h bf=%0b fpc=%08h", i, w_mem_address, w_block_fetch, w_fetch_pc);
            next_cycle();
        end

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            model_reset(32'h0);
            for (int c = 0; c < 120; c++) begin
                halting       = ($urandom_range(0, 79) == 0);
                jump          = ($urandom_range(0, 5) == 0);
                jump_address  = $urandom;
                data_req      = ($urandom_range(0, 2) == 0);
                data_write    = $urandom_range(0, 1);
                data_address  = $urandom;
                data_wr_value = $urandom;
                #3;
                model_check(c);
                model_step();
                next_cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Drives the memory bus that feeds instruction fetch stage 0. Each cycle it owns one bus slot and arbitrates it between an instruction fetch at the program counter and a data load/store requested by a later pipeline stage. It applies jump redirects and stops fetching on halt. Its registered `block_fetch` tells fetch stage 0 when `mem_data` does not hold a valid next instruction.

## Interface
Parameters:
- `RESET_PC`, 32'h00000000, first fetch address after reset; low two bits are zero.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `halting`  in  1  from fetch stage 0; enter HALTED.
- `jump`  in  1  redirect request, valid for one cycle.
- `jump_address`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `data_req`  in  1  a later stage requests this cycle's bus slot.
- `data_write`  in  1  1 = store, 0 = load; qualified by `data_req`.
- `data_address`  in  32  load/store address, passed through unmodified.
- `data_wr_value`  in  32  store data.
- `mem_address`  out  32  bus address; combinational.
- `mem_read`  out  1  read strobe; combinational.
- `mem_write`  out  1  write strobe; combinational.
- `mem_wr_data`  out  32  equals `data_wr_value`; combinational.
- `block_fetch`  out  1  registered; `mem_data` this cycle is not a valid instruction.
- `data_ack`  out  1  registered; `mem_data` this cycle holds the result of last cycle's load.
- `fetch_pc`  out  32  registered; address of the instruction currently on `mem_data`.

## Operation
- Memory is a synchronous single-cycle RAM. An address presented in cycle N produces `mem_data` in cycle N+1, which fetch stage 0 samples at the end of N+1.
- Internal state: `pc` (32 bits, bits [1:0] always 0) and `state` ∈ {RUN, HALTED}.
- Slot selection in RUN, priority order:
  - `data_req`=1: data slot. `mem_address`=`data_address`, `mem_read`=!`data_write`, `mem_write`=`data_write`. `pc` is not incremented.
  - otherwise: fetch slot. `mem_address`=`pc`, `mem_read`=1, `mem_write`=0. `pc` advances by 4 at the edge.
- Jump: if `jump`=1 in a RUN cycle, `pc` takes `{jump_address[31:2],2'b00}` at the edge. This overrides the increment, whatever slot type the cycle has. A fetch slot taken in the jump cycle is wrong-path and gets squashed.
- Slot classification at each edge (registered into the outputs):
  - `block_fetch` = 1 unless the slot just ending was a fetch slot with `jump`=0.
  - `data_ack` = 1 iff the slot was a data slot with `data_write`=0.
  - `fetch_pc` = the `mem_address` of a fetch slot. It holds its value after any other slot type.
- HALTED: entered at the edge where `halting`=1, from RUN. Exits only via reset.
  - `mem_read`=`mem_write`=0 and `mem_address`=`pc`.
  - `pc` frozen; `jump` and `data_req` ignored.
  - From the next cycle on, `block_fetch`=1 and `data_ack`=0.
  - The slot in the cycle where `halting` is first seen still follows RUN rules.
- Arithmetic: `pc`+4 wraps modulo 2^32 (32'hFFFFFFFC → 32'h00000000); no overflow flag.
- Simultaneous `jump` and `data_req`: the data slot proceeds and `pc` loads the jump target, so the next fetch is the target.
- Simultaneous `jump` and `halting`: the halt wins from the next cycle; `pc` still loads the target, which is visible for debug.

## Timing
- Reset (asynchronous, immediate):
  - `pc`=`RESET_PC`, `state`=RUN, `block_fetch`=1, `data_ack`=0, `fetch_pc`=`RESET_PC`.
  - The combinational outputs follow: `mem_address`=`RESET_PC`, `mem_read`=1, `mem_write`=0 (assuming `data_req`=0).
- First cycle after reset release: fetch of `RESET_PC`. The instruction arrives in cycle 1 with `block_fetch`=0.
- Fetch latency: address in cycle N → instruction valid on `mem_data` in N+1, with `block_fetch`=0 and `fetch_pc`=that address.
- A data slot costs exactly one fetch bubble. A jump squashes exactly one slot, so the target instruction reaches `mem_data` two cycles after `jump`.
- Reset asserted mid-operation abandons any in-flight slot. No partial write is suppressed beyond what the RAM itself does on that cycle.
- `data_req` and the data inputs are sampled combinationally. They must be stable before the edge in the same cycle.

## Test plan
- Reset release, no requests, 4 cycles → `mem_address` 0,4,8,C; `block_fetch` 1,0,0,0; `fetch_pc` 0,0,4,8 (per cycle).
- `data_req`=1, `data_write`=0, `data_address`=0x100 in cycle 2 → `mem_address`=0x100 in cycle 2. Cycle 3: `block_fetch`=1, `data_ack`=1, `mem_address`=8 (PC held).
- `jump`=1, `jump_address`=0x203 in cycle 3 → cycle 4: `mem_address`=0x200, `block_fetch`=1. Cycle 5: `block_fetch`=0, `fetch_pc`=0x200.
- Store plus jump in the same cycle → `mem_write`=1 at `data_address` that cycle. Next cycle: `mem_address`=jump target, `data_ack`=0, `block_fetch`=1.
- `RESET_PC`=32'hFFFFFFF8, free run → addresses FFFFFFF8, FFFFFFFC, 00000000.
- `halting`=1 in cycle 5 → from cycle 6: `mem_read`=0, PC frozen, `block_fetch`=1. A `jump` or `data_req` in cycle 7 has no effect. Asynchronous reset in cycle 9 restores all reset values immediately.
